// File: rtl/mmio_pkg.sv
// Shared types and default address map for the MMIO bus decoder.
// Masks are full address width so the map does not alias above 0xFF.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mmio_state_t;

  localparam int ERR_CNT_W = 8;

  localparam logic [31:0] RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK = 32'hFFFF_FF80;
  localparam logic [31:0] IO1_BASE = 32'h0000_0080;
  localparam logic [31:0] IO2_BASE = 32'h0000_0090;
  localparam logic [31:0] IO3_BASE = 32'h0000_00A0;
  localparam logic [31:0] IO_MASK  = 32'hFFFF_FFF0;

  localparam logic [127:0] DEFAULT_BASE_ADDRS = {IO3_BASE, IO2_BASE, IO1_BASE, RAM_BASE};
  localparam logic [127:0] DEFAULT_ADDR_MASKS = {IO_MASK, IO_MASK, IO_MASK, RAM_MASK};

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mmio_addr_match.sv
// Combinational BASE/MASK address matcher; the lowest matching slave index wins.
module mmio_addr_match #(
  parameter int N_SLAVES = 4,
  parameter int AW = 32,
  parameter logic [N_SLAVES*AW-1:0] BASE_ADDRS = '0,
  parameter logic [N_SLAVES*AW-1:0] ADDR_MASKS = '0,
  localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic [IW-1:0] idx
);

  // Scan from the top so the last assignment comes from the lowest index.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr & ADDR_MASKS[i*AW +: AW]) == BASE_ADDRS[i*AW +: AW]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/mmio_bus_decoder.sv
// CPU-to-slave MMIO decoder with req/ack stall handshake and bus-error reporting.
// Define MMIO_DEC_TIMEOUT_EN to abort accesses that see no ack within TIMEOUT_CYC cycles.
module mmio_bus_decoder
  import mmio_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [N_SLAVES*AW-1:0] BASE_ADDRS = DEFAULT_BASE_ADDRS,
  parameter logic [N_SLAVES*AW-1:0] ADDR_MASKS = DEFAULT_ADDR_MASKS,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [AW-1:0]          cpu_addr,
  input  logic [DW-1:0]          cpu_wdata,
  input  logic [DW/8-1:0]        cpu_be,
  output logic [DW-1:0]          cpu_rdata,
  output logic                   cpu_ready,
  output logic                   cpu_err,
  output logic [N_SLAVES-1:0]    s_sel,
  output logic                   s_we,
  output logic [AW-1:0]          s_addr,
  output logic [DW-1:0]          s_wdata,
  output logic [DW/8-1:0]        s_be,
  input  logic [N_SLAVES*DW-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]    s_ack,
  output logic [ERR_CNT_W-1:0]   err_cnt,
  output logic [AW-1:0]          err_addr
);

  localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  mmio_state_t   state;
  logic          hit;
  logic [IW-1:0] dec_idx;
  logic [IW-1:0] idx;
  logic          err;
  logic          sel_ack;
  logic [DW-1:0] sel_rdata;
  logic          timeout;

  mmio_addr_match #(
    .N_SLAVES  (N_SLAVES),
    .AW        (AW),
    .BASE_ADDRS(BASE_ADDRS),
    .ADDR_MASKS(ADDR_MASKS)
  ) u_match (
    .addr(cpu_addr),
    .hit (hit),
    .idx (dec_idx)
  );

  // Only the latched slave's ack and read data are ever looked at.
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    s_sel     = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (idx == IW'(i)) begin
        sel_ack   = s_ack[i];
        sel_rdata = s_rdata[i*DW +: DW];
        s_sel[i]  = (state == ACCESS);
      end
    end
  end

  assign cpu_ready = (state == RESP);
  assign cpu_err   = (state == RESP) && err;

`ifdef MMIO_DEC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state != ACCESS) begin
      wait_cnt <= '0;
    end else if (!sel_ack) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = (wait_cnt == CW'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      err       <= 1'b0;
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_be      <= '0;
      cpu_rdata <= '0;
      err_cnt   <= '0;
      err_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (hit) begin
              state   <= ACCESS;
              idx     <= dec_idx;
              err     <= 1'b0;
              s_we    <= cpu_we;
              s_addr  <= cpu_addr;
              s_wdata <= cpu_wdata;
              s_be    <= cpu_be;
            end else begin
              state     <= RESP;
              err       <= 1'b1;
              cpu_rdata <= '0;
              err_addr  <= cpu_addr;
              err_cnt   <= sat_inc(err_cnt);
            end
          end
        end
        // A late ack still beats a timeout landing in the same cycle.
        ACCESS: begin
          if (sel_ack) begin
            state     <= RESP;
            err       <= 1'b0;
            cpu_rdata <= s_we ? '0 : sel_rdata;
          end else if (timeout) begin
            state     <= RESP;
            err       <= 1'b1;
            cpu_rdata <= '0;
            err_addr  <= s_addr;
            err_cnt   <= sat_inc(err_cnt);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_decoder.sv
// Directed self-checking bench for mmio_bus_decoder (default map plus an overlapping-map instance).
// Timeout scenarios are exercised when MMIO_DEC_TIMEOUT_EN is defined.
module tb_mmio_bus_decoder;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cpu_req = 1'b0;
  logic         req_ov = 1'b0;
  logic         cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [3:0]   cpu_be = '0;
  logic [127:0] s_rdata = '0;
  logic [3:0]   s_ack = '0;

  logic [31:0] cpu_rdata, s_addr, s_wdata, err_addr;
  logic        cpu_ready, cpu_err, s_we;
  logic [3:0]  s_sel, s_be;
  logic [7:0]  err_cnt;

  logic [31:0] ov_rdata, ov_s_addr, ov_s_wdata, ov_err_addr;
  logic        ov_ready, ov_err, ov_s_we;
  logic [3:0]  ov_s_sel, ov_s_be;
  logic [7:0]  ov_err_cnt;

  int total = 0;
  int bad = 0;
  int exp_err_cnt = 0;

  int          obs_edges, obs_sel_cycles;
  logic [3:0]  obs_sel;
  logic [31:0] obs_rdata, obs_addr, obs_wdata;
  logic        obs_err, obs_we;

  always #5 clk = ~clk;

  mmio_bus_decoder #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .cpu_err(cpu_err), .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_be(s_be), .s_rdata(s_rdata), .s_ack(s_ack), .err_cnt(err_cnt), .err_addr(err_addr)
  );

  // Slave 1 widened to 0x80-0xFF so it overlaps slaves 2 and 3.
  mmio_bus_decoder #(
    .ADDR_MASKS({32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FF80, 32'hFFFF_FF80}),
    .TIMEOUT_CYC(4)
  ) dut_ov (
    .clk(clk), .rst(rst), .cpu_req(req_ov), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_rdata(ov_rdata), .cpu_ready(ov_ready),
    .cpu_err(ov_err), .s_sel(ov_s_sel), .s_we(ov_s_we), .s_addr(ov_s_addr), .s_wdata(ov_s_wdata),
    .s_be(ov_s_be), .s_rdata(s_rdata), .s_ack(s_ack), .err_cnt(ov_err_cnt), .err_addr(ov_err_addr)
  );

  // Drives one access on the main instance and records what it saw; ack_slave < 0 means no ack.
  task automatic run_access(input bit chain, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ack_slave,
                            input int ack_delay, input logic [31:0] slave_data);
    bit done = 0;
    if (!chain) @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = 4'hF;
    if (ack_slave >= 0) s_rdata[ack_slave*32 +: 32] = slave_data;
    obs_edges = 0; obs_sel_cycles = 0; obs_sel = '0;
    obs_rdata = '0; obs_err = 1'b0; obs_we = 1'b0; obs_addr = '0; obs_wdata = '0;
    while (!done && obs_edges < 100) begin
      @(posedge clk);
      obs_edges++;
      @(negedge clk);
      s_ack = '0;
      if (cpu_ready) begin
        done = 1;
        obs_rdata = cpu_rdata;
        obs_err = cpu_err;
        cpu_req = 1'b0;
      end else if (s_sel != '0) begin
        if (obs_sel_cycles == 0) begin
          obs_we = s_we; obs_addr = s_addr; obs_wdata = s_wdata;
        end
        obs_sel |= s_sel;
        if (ack_slave >= 0 && obs_sel_cycles == ack_delay) s_ack[ack_slave] = 1'b1;
        obs_sel_cycles++;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("[TB] FAIL access_bound addr=%h: no cpu_ready within 100 edges", addr);
      cpu_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (cpu_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=0", cpu_ready); end
    total++; if (cpu_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b exp=0", cpu_err); end
    total++; if (s_sel !== 4'b0) begin bad++; $display("[TB] FAIL reset_sel got=%b exp=0000", s_sel); end
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata got=%h exp=0", cpu_rdata); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    total++; if ({s_we, s_addr, s_be} !== 37'h0) begin bad++; $display("[TB] FAIL reset_latches got=%h exp=0", {s_we, s_addr, s_be}); end
    rst = 1'b1;
  endtask

  task automatic test_read_hit();
    run_access(0, 1'b0, 32'h40, 32'h0, 0, 0, 32'h1234_5678);
    total++; if (obs_edges != 2) begin bad++; $display("[TB] FAIL read_latency got=%0d exp=2", obs_edges); end
    total++; if (obs_sel !== 4'b0001) begin bad++; $display("[TB] FAIL read_sel got=%b exp=0001", obs_sel); end
    total++; if (obs_rdata !== 32'h1234_5678) begin bad++; $display("[TB] FAIL read_rdata got=%h exp=12345678", obs_rdata); end
    total++; if (obs_err !== 1'b0) begin bad++; $display("[TB] FAIL read_err got=%b exp=0", obs_err); end
    @(negedge clk);
    total++; if (cpu_ready !== 1'b0) begin bad++; $display("[TB] FAIL read_ready_pulse got=%b exp=0", cpu_ready); end
    total++; if (cpu_rdata !== 32'h1234_5678) begin bad++; $display("[TB] FAIL read_rdata_hold got=%h exp=12345678", cpu_rdata); end
  endtask

  task automatic test_miss();
    run_access(0, 1'b0, 32'h100, 32'h0, -1, 0, 32'h0);
    exp_err_cnt++;
    total++; if (obs_edges != 1) begin bad++; $display("[TB] FAIL miss_latency got=%0d exp=1", obs_edges); end
    total++; if (obs_sel !== 4'b0) begin bad++; $display("[TB] FAIL miss_sel got=%b exp=0000", obs_sel); end
    total++; if (obs_err !== 1'b1) begin bad++; $display("[TB] FAIL miss_err got=%b exp=1", obs_err); end
    total++; if (obs_rdata !== 32'h0) begin bad++; $display("[TB] FAIL miss_rdata got=%h exp=0", obs_rdata); end
    total++; if (err_cnt !== 8'(exp_err_cnt)) begin bad++; $display("[TB] FAIL miss_err_cnt got=%0d exp=%0d", err_cnt, exp_err_cnt); end
    total++; if (err_addr !== 32'h100) begin bad++; $display("[TB] FAIL miss_err_addr got=%h exp=100", err_addr); end
  endtask

  task automatic test_write_wait();
    run_access(0, 1'b1, 32'h84, 32'hFF, 1, 3, 32'hDEAD_BEEF);
    total++; if (obs_edges != 5) begin bad++; $display("[TB] FAIL write_latency got=%0d exp=5", obs_edges); end
    total++; if (obs_sel !== 4'b0010) begin bad++; $display("[TB] FAIL write_sel got=%b exp=0010", obs_sel); end
    total++; if (obs_sel_cycles != 4) begin bad++; $display("[TB] FAIL write_sel_cycles got=%0d exp=4", obs_sel_cycles); end
    total++; if ({obs_we, obs_addr, obs_wdata} !== {1'b1, 32'h84, 32'hFF}) begin
      bad++; $display("[TB] FAIL write_latch got=%b/%h/%h exp=1/84/ff", obs_we, obs_addr, obs_wdata);
    end
    total++; if (obs_rdata !== 32'h0) begin bad++; $display("[TB] FAIL write_rdata got=%h exp=0", obs_rdata); end
    total++; if (obs_err !== 1'b0) begin bad++; $display("[TB] FAIL write_err got=%b exp=0", obs_err); end
  endtask

  task automatic test_back_to_back();
    run_access(0, 1'b0, 32'h00, 32'h0, 0, 0, 32'h55);
    run_access(1, 1'b0, 32'h200, 32'h0, -1, 0, 32'h0);
    exp_err_cnt++;
    total++; if (obs_edges != 2 || obs_err !== 1'b1) begin
      bad++; $display("[TB] FAIL b2b_miss got edges=%0d err=%b exp edges=2 err=1", obs_edges, obs_err);
    end
    total++; if (err_cnt !== 8'(exp_err_cnt) || err_addr !== 32'h200) begin
      bad++; $display("[TB] FAIL b2b_err_regs got=%0d/%h exp=%0d/200", err_cnt, err_addr, exp_err_cnt);
    end
    run_access(1, 1'b0, 32'hA4, 32'h0, 3, 0, 32'h77);
    total++; if (obs_edges != 3 || obs_sel !== 4'b1000 || obs_rdata !== 32'h77) begin
      bad++; $display("[TB] FAIL b2b_hit got edges=%0d sel=%b rdata=%h exp edges=3 sel=1000 rdata=77", obs_edges, obs_sel, obs_rdata);
    end
  endtask

`ifdef MMIO_DEC_TIMEOUT_EN
  task automatic test_timeout();
    run_access(0, 1'b0, 32'h94, 32'h0, -1, 0, 32'h0);
    exp_err_cnt++;
    total++; if (obs_edges != 5 || obs_sel_cycles != 4) begin
      bad++; $display("[TB] FAIL timeout_latency got edges=%0d sel_cycles=%0d exp 5/4", obs_edges, obs_sel_cycles);
    end
    total++; if (obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
      bad++; $display("[TB] FAIL timeout_err got err=%b rdata=%h exp 1/0", obs_err, obs_rdata);
    end
    total++; if (err_cnt !== 8'(exp_err_cnt) || err_addr !== 32'h94) begin
      bad++; $display("[TB] FAIL timeout_err_regs got=%0d/%h exp=%0d/94", err_cnt, err_addr, exp_err_cnt);
    end
    run_access(0, 1'b0, 32'h94, 32'h0, 2, 3, 32'hABCD);
    total++; if (obs_edges != 5 || obs_err !== 1'b0 || obs_rdata !== 32'hABCD) begin
      bad++; $display("[TB] FAIL timeout_ack_wins got edges=%0d err=%b rdata=%h exp 5/0/abcd", obs_edges, obs_err, obs_rdata);
    end
  endtask
`else
  task automatic test_long_wait();
    run_access(0, 1'b0, 32'h94, 32'h0, 2, 10, 32'hABCD);
    total++; if (obs_edges != 12 || obs_sel_cycles != 11) begin
      bad++; $display("[TB] FAIL long_wait_latency got edges=%0d sel_cycles=%0d exp 12/11", obs_edges, obs_sel_cycles);
    end
    total++; if (obs_err !== 1'b0 || obs_rdata !== 32'hABCD || obs_sel !== 4'b0100) begin
      bad++; $display("[TB] FAIL long_wait_result got err=%b rdata=%h sel=%b exp 0/abcd/0100", obs_err, obs_rdata, obs_sel);
    end
  endtask
`endif

  task automatic test_overlap();
    @(negedge clk);
    req_ov = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h90;
    s_rdata[32 +: 32] = 32'hCAFE_0001;
    s_rdata[96 +: 32] = 32'hBAD0_0003;
    @(posedge clk); @(negedge clk);
    total++; if (ov_s_sel !== 4'b0010) begin bad++; $display("[TB] FAIL overlap_sel got=%b exp=0010", ov_s_sel); end
    s_ack = 4'b1000;
    @(posedge clk); @(negedge clk);
    total++; if (ov_s_sel !== 4'b0010 || ov_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL overlap_stray_ack got sel=%b ready=%b exp 0010/0", ov_s_sel, ov_ready);
    end
    s_ack = 4'b0010;
    @(posedge clk); @(negedge clk);
    s_ack = 4'b0000; req_ov = 1'b0;
    total++; if (ov_ready !== 1'b1 || ov_err !== 1'b0 || ov_rdata !== 32'hCAFE_0001) begin
      bad++; $display("[TB] FAIL overlap_resp got ready=%b err=%b rdata=%h exp 1/0/cafe0001", ov_ready, ov_err, ov_rdata);
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
    repeat (600) @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    total++; if (err_cnt !== 8'd255) begin bad++; $display("[TB] FAIL saturate_cnt got=%0d exp=255", err_cnt); end
    total++; if (err_addr !== 32'h300) begin bad++; $display("[TB] FAIL saturate_addr got=%h exp=300", err_addr); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    @(posedge clk); @(negedge clk);
    total++; if (s_sel !== 4'b0001) begin bad++; $display("[TB] FAIL midrst_pre_sel got=%b exp=0001", s_sel); end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (s_sel !== 4'b0 || cpu_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL midrst_outputs got sel=%b ready=%b exp 0000/0", s_sel, cpu_ready);
    end
    total++; if (err_cnt !== 8'd0 || err_addr !== 32'h0 || cpu_rdata !== 32'h0) begin
      bad++; $display("[TB] FAIL midrst_regs got cnt=%0d addr=%h rdata=%h exp 0/0/0", err_cnt, err_addr, cpu_rdata);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_access(0, 1'b0, 32'h08, 32'h0, 0, 0, 32'h0BAD_F00D);
    total++; if (obs_edges != 2 || obs_rdata !== 32'h0BAD_F00D) begin
      bad++; $display("[TB] FAIL midrst_recover got edges=%0d rdata=%h exp 2/0badf00d", obs_edges, obs_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_miss();
    test_write_wait();
    test_back_to_back();
`ifdef MMIO_DEC_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_overlap();
    test_saturate();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
